cpu_wb_bus_if: RTL

- Bridges one OpenMIPS single-cycle memory port (instruction fetch or data access) to a Wishbone classic master interface.
- Sits directly downstream of the processor's memory port. Two instances are used: one for rom_*, one for ram_*.
- Raises a stall request to ctrl while a bus cycle is outstanding.
- Holds returned read data until the pipeline stall releases, so the consuming stage samples it exactly once.

---
 rtl/cpu_wb_bus_if_if.sv | 26 ++
 rtl/cpu_wb_bus_if.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cpu_wb_bus_if_if.sv
// Wishbone classic bus bundle used between cpu_wb_bus_if and a Wishbone slave.
//   master modport : bridge side (drives addr/data/we/sel/stb/cyc, takes data/ack)
//   slave  modport : memory/peripheral side
// Signal names keep the bridge's port naming, so *_o means driven by the master.
interface cpu_wb_bus_if_if;
  logic [31:0] wishbone_data_i;
  logic        wishbone_ack_i;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;

  modport master (
    input  wishbone_data_i, wishbone_ack_i,
    output wishbone_addr_o, wishbone_data_o, wishbone_we_o,
           wishbone_sel_o, wishbone_stb_o, wishbone_cyc_o
  );

  modport slave (
    output wishbone_data_i, wishbone_ack_i,
    input  wishbone_addr_o, wishbone_data_o, wishbone_we_o,
           wishbone_sel_o, wishbone_stb_o, wishbone_cyc_o
  );
endinterface

// File: rtl/cpu_wb_bus_if.sv
// Bridge from one OpenMIPS single-cycle memory port to a Wishbone classic master.
// Asserts stallreq while a bus cycle is outstanding and holds read data in
// rd_buf until the pipeline stall releases, so the consumer samples it once.
// Ports:
//   clk, rst            clock, async active-low reset
//   stall_i[5:0]        pipeline stall vector from ctrl
//   flush_i             pipeline flush, aborts any access
//   cpu_ce_i/addr/data/we/sel   CPU request
//   cpu_data_o          read data returned to CPU
//   stallreq            stall request to ctrl
//   bus_err_o           one-cycle pulse when an access times out
//   wb                  Wishbone classic master (all outputs registered)
// TIMEOUT_CYCLES must be >= 1 and fit in CNT_W bits (2^CNT_W > TIMEOUT_CYCLES).
module cpu_wb_bus_if #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stall_i,
  input  logic                 flush_i,
  input  logic                 cpu_ce_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  input  logic                 cpu_we_i,
  input  logic [3:0]           cpu_sel_i,
  output logic [31:0]          cpu_data_o,
  output logic                 stallreq,
  output logic                 bus_err_o,
  cpu_wb_bus_if_if.master      wb
);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_FOR_STALL} state_t;

  state_t      state, state_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] data_q, data_n;
  logic        we_q, we_n;
  logic [3:0]  sel_q, sel_n;
  logic        req_q, req_n;     // drives both stb and cyc
  logic [31:0] rd_buf, rd_buf_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic clr;                     // drop the whole bus this cycle
  logic ack;
  logic timeout;
  logic stall_any;

  assign ack       = wb.wishbone_ack_i;
  assign timeout   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign stall_any = |stall_i;

  assign wb.wishbone_addr_o = addr_q;
  assign wb.wishbone_data_o = data_q;
  assign wb.wishbone_we_o   = we_q;
  assign wb.wishbone_sel_o  = sel_q;
  assign wb.wishbone_stb_o  = req_q;
  assign wb.wishbone_cyc_o  = req_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      req_q  <= 1'b0;
      rd_buf <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      addr_q <= addr_n;
      data_q <= data_n;
      we_q   <= we_n;
      sel_q  <= sel_n;
      req_q  <= req_n;
      rd_buf <= rd_buf_n;
      cnt    <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    addr_n     = addr_q;
    data_n     = data_q;
    we_n       = we_q;
    sel_n      = sel_q;
    req_n      = req_q;
    rd_buf_n   = rd_buf;
    cnt_n      = cnt;
    clr        = 1'b0;
    stallreq   = 1'b0;
    cpu_data_o = '0;
    bus_err_o  = 1'b0;

    case (state)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          addr_n   = cpu_addr_i;
          data_n   = cpu_data_i;
          we_n     = cpu_we_i;
          sel_n    = cpu_sel_i;
          req_n    = 1'b1;
          cnt_n    = '0;
          state_n  = BUSY;
          stallreq = 1'b1;
        end else begin
          clr = 1'b1;
        end
      end

      BUSY: begin
        if (flush_i) begin
          // Abort; a slave ack arriving later lands in IDLE and is ignored.
          clr      = 1'b1;
          rd_buf_n = '0;
          state_n  = IDLE;
        end else if (ack) begin
          clr = 1'b1;
          if (!we_q) begin
            rd_buf_n   = wb.wishbone_data_i;
            cpu_data_o = wb.wishbone_data_i;   // same-cycle forward
          end
          state_n = stall_any ? WAIT_FOR_STALL : IDLE;
        end else if (timeout) begin
          clr       = 1'b1;
          rd_buf_n  = '0;
          bus_err_o = 1'b1;
          state_n   = stall_any ? WAIT_FOR_STALL : IDLE;
        end else begin
          cnt_n    = cnt + CNT_W'(1);
          stallreq = 1'b1;
        end
      end

      WAIT_FOR_STALL: begin
        // Present the buffered word until the stalled stage moves on.
        cpu_data_o = rd_buf;
        if (flush_i || !stall_any) state_n = IDLE;
      end

      default: begin
        clr     = 1'b1;
        state_n = IDLE;
      end
    endcase

    if (clr) begin
      addr_n = '0;
      data_n = '0;
      we_n   = 1'b0;
      sel_n  = '0;
      req_n  = 1'b0;
    end
  end

endmodule
